ls_quad_gate_tester: RTL
========================

# ls_quad_gate_tester

Sequential stimulus/check engine that exercises a quad 2-input NAND device (74LS00 pinout model or real part behind I/O) from the driving side. On `start` it walks the four input vectors across all four gates in parallel, waits a programmable settle time per vector, samples the gate outputs and accumulates a per-gate failure mask. It sits between the board-level test sequencer and the device-under-test pins in the 74-series logic library.

## Interface
- `SETTLE_CYCLES`, default 4, clock cycles each vector is held before sampling; legal range 1..255.
- `clk`  input  1  sole clock, all state on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  begin a test run; honoured only in IDLE.
- `y`  input  4  sensed DUT outputs, bit i = gate i+1 (y1..y4).
- `a`  output  4  driven DUT A inputs, bit i = gate i+1; reset 4'b0000.
- `b`  output  4  driven DUT B inputs, bit i = gate i+1; reset 4'b0000.
- `busy`  output  1  run in progress; reset 0.
- `done`  output  1  one-cycle pulse at end of run; reset 0.
- `pass`  output  1  last run had no mismatch; reset 0, held until next start.
- `fail_mask`  output  4  bit i set if gate i+1 mismatched on any vector; reset 4'b0000.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE. Reset forces IDLE, vector index 0, settle counter 0, all outputs to reset values.
- IDLE: `a=b=0`. `start=1` -> SETTLE, vec=0, cnt=0, `busy=1`, `fail_mask` cleared, `pass` cleared.
- Vector order (a,b) applied to all four gates identically: vec0=(0,0), vec1=(0,1), vec2=(1,0), vec3=(1,1); `a`/`b` = 4 copies of the bit.
- Expected `y` per vector: 4'b1111, 4'b1111, 4'b1111, 4'b0000.
- SETTLE: cnt increments each cycle; when cnt == SETTLE_CYCLES-1 -> SAMPLE.
- SAMPLE (one cycle): `fail_mask <= fail_mask | (y ^ expected)`. If vec<3: vec++, cnt=0 -> SETTLE. If vec==3 -> DONE.
- DONE (one cycle): `done=1`, `busy=0`, `pass = (fail_mask == 0)` registered on entry; `a=b=0`; -> IDLE.
- `start` while not in IDLE ignored, no restart, no effect on mask.
- `start` held high continuously: new run begins on the IDLE cycle after DONE.
- Reset mid-run: immediate return to IDLE, no `done` pulse, mask and pass cleared.
- Stuck-at-1 output caught only on vec3; stuck-at-0 caught on vec0..vec2; mask is sticky within a run.

## Timing
- Let S = SETTLE_CYCLES. `start` sampled high at edge 0 -> `busy`=1 and vec0 on `a`/`b` from cycle 1.
- Vector k driven during cycles 1+k(S+1) .. (k+1)(S+1); sampled in last of those cycles.
- `done` high in cycle 4(S+1)+1 only; `pass`/`fail_mask` valid from that cycle.
- S=4: vectors change at cycles 1, 6, 11, 16; `done` at cycle 21.
- Back-to-back: earliest next start accepted in IDLE cycle 4(S+1)+2.
- `a`, `b`, `busy`, `done`, `pass`, `fail_mask` all registered; no combinational path from `y` or `start` to outputs.

## Configuration
- `LS_TESTER_INPUT_SYNC_EN` defined: `y` passes through a 2-flop synchronizer before comparison; each SETTLE window extended by 2 cycles (cnt terminal value S+1) so the compared sample reflects the current vector. Run length becomes 4(S+3)+1 cycles.
- Undefined: `y` compared directly in SAMPLE; timing as above.

## Test plan
- Ideal NAND model on `y`, S=4, start pulse at cycle 0 -> vectors at 1/6/11/16, `done` at cycle 21, `pass=1`, `fail_mask=4'b0000`.
- Gate 3 output stuck at 1 -> `fail_mask=4'b0100`, `pass=0`; gate 1 stuck at 0 -> `fail_mask=4'b0001`.
- Model with y2 and y4 forced to AND function -> `fail_mask=4'b1010`, `pass=0`; next run with ideal model clears to 4'b0000, `pass=1`.
- `start` re-pulsed at cycles 5 and 15 -> ignored, `done` still only at cycle 21, single run.
- `rst` asserted at cycle 10 -> cycle 11 `busy=0`, `a=b=0`, `fail_mask=0`, no `done` thereafter until new start.
- With `LS_TESTER_INPUT_SYNC_EN`, S=4, ideal model -> `done` at cycle 29, `pass=1`.

Source files
------------

// File: rtl/ls_quad_gate_tester.sv
// ls_quad_gate_tester: drives the four NAND truth-table vectors onto all four
// gates of a quad 2-input NAND part, holds each vector for SETTLE_CYCLES, samples
// the sensed outputs and accumulates a sticky per-gate failure mask.
// Optional build macro: LS_TESTER_INPUT_SYNC_EN puts a 2-flop synchronizer on
// i_y and stretches each settle window by two cycles to cover its latency.
module ls_quad_gate_tester #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [3:0] i_y,
  output logic [3:0] o_a,
  output logic [3:0] o_b,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [3:0] o_fail_mask
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

`ifdef LS_TESTER_INPUT_SYNC_EN
  localparam logic [8:0] CNT_LAST = 9'(SETTLE_CYCLES + 1);
`else
  localparam logic [8:0] CNT_LAST = 9'(SETTLE_CYCLES - 1);
`endif

  logic [1:0] r_state;
  logic [1:0] r_vec;
  logic [8:0] r_cnt;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_fail_mask;

  logic [3:0] w_y_cmp;
  logic [3:0] w_expected;
  logic [3:0] w_mask_next;
  logic [1:0] w_vec_next;

`ifdef LS_TESTER_INPUT_SYNC_EN
  logic [3:0] r_y_sync1;
  logic [3:0] r_y_sync2;

  // Two-stage synchronizer on the sensed device outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_y_sync1 <= '0;
      r_y_sync2 <= '0;
    end else begin
      r_y_sync1 <= i_y;
      r_y_sync2 <= r_y_sync1;
    end
  end

  assign w_y_cmp = r_y_sync2;
`else
  assign w_y_cmp = i_y;
`endif

  // Expected NAND response and the mask/vector values produced by a sample
  always_comb begin
    w_expected  = (r_vec == 2'd3) ? 4'b0000 : 4'b1111;
    w_mask_next = r_fail_mask | (w_y_cmp ^ w_expected);
    w_vec_next  = r_vec + 2'd1;
  end

  // Run sequencer: vector stepping, settle timing, sampling and result capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_vec       <= '0;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_mask <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state     <= ST_SETTLE;
            r_vec       <= '0;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_busy      <= 1'b1;
            r_pass      <= 1'b0;
            r_fail_mask <= '0;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_SAMPLE;
          end else begin
            r_cnt <= r_cnt + 9'd1;
          end
        end
        ST_SAMPLE: begin
          r_fail_mask <= w_mask_next;
          if (r_vec != 2'd3) begin
            r_vec   <= w_vec_next;
            r_cnt   <= '0;
            r_a     <= {4{w_vec_next[1]}};
            r_b     <= {4{w_vec_next[0]}};
            r_state <= ST_SETTLE;
          end else begin
            // pass is taken from the mask including this last sample so it is
            // valid in the same cycle as the done pulse
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_pass  <= (w_mask_next == 4'b0000);
            r_a     <= '0;
            r_b     <= '0;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_a         = r_a;
  assign o_b         = r_b;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_fail_mask = r_fail_mask;

endmodule
